// File: rtl/lzw_pkg.sv
// Shared state encoding, constants and slot hash for the LZW stream encoder.
package lzw_pkg;

  localparam int LITERAL_CODES = 256;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PROBE,
    EMIT,
    EMIT_LAST
  } lzw_state_e;

  // Slot index = prefix XOR (byte << (code_width-8)), truncated to code_width bits.
  function automatic logic [15:0] lzw_hash(input int code_width,
                                           input logic [15:0] prefix,
                                           input logic [7:0] byte_in);
    logic [16:0] mask;
    logic [15:0] shifted;
    mask    = (17'd1 << code_width) - 17'd1;
    shifted = {8'd0, byte_in} << (code_width - 8);
    return (prefix ^ shifted) & mask[15:0];
  endfunction

endpackage

// File: rtl/lzw_hash_table.sv
// Dictionary store: 1-cycle synchronous key/code RAM plus flop valid bits.
// Reads return next cycle; one write per cycle; clear_all_i wipes every valid bit in one cycle.
module lzw_hash_table #(
  parameter int CODE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_all_i,
  input  logic                    rd_en_i,
  input  logic [CODE_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_vld_o,
  output logic [CODE_WIDTH+7:0]   rd_key_o,
  output logic [CODE_WIDTH-1:0]   rd_code_o,
  input  logic                    wr_en_i,
  input  logic [CODE_WIDTH-1:0]   wr_addr_i,
  input  logic [CODE_WIDTH+7:0]   wr_key_i,
  input  logic [CODE_WIDTH-1:0]   wr_code_i
);
  localparam int DEPTH = 1 << CODE_WIDTH;

  logic [CODE_WIDTH+7:0] key_mem  [DEPTH];
  logic [CODE_WIDTH-1:0] code_mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic                  rd_vld_q;
  logic [CODE_WIDTH+7:0] rd_key_q;
  logic [CODE_WIDTH-1:0] rd_code_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      key_mem[wr_addr_i]  <= wr_key_i;
      code_mem[wr_addr_i] <= wr_code_i;
    end
    if (rd_en_i) begin
      rd_key_q  <= key_mem[rd_addr_i];
      rd_code_q <= code_mem[rd_addr_i];
    end
  end

  // A read racing a clear must not see a stale entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (clear_all_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_addr_i] <= 1'b1;
      end
      if (rd_en_i) begin
        rd_vld_q <= valid_q[rd_addr_i] & ~clear_all_i;
      end
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign rd_key_o  = rd_key_q;
  assign rd_code_o = rd_code_q;

endmodule

// File: rtl/lzw_stream_encoder.sv
// LZW byte-stream compressor: one hash probe per cycle, codes emitted on a valid/ready port.
// Input stalls outside IDLE/WAIT; each emitted code is held until out_ready.
module lzw_stream_encoder
  import lzw_pkg::*;
#(
  parameter int CODE_WIDTH  = 12,
  parameter int PROBE_LIMIT = 8,
  parameter int FULL_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic                  out_last,
  output logic                  dict_full,
  output logic                  busy
);
  localparam int CW = CODE_WIDTH;
  localparam logic [CW:0] FIRST_CODE = (CW+1)'(LITERAL_CODES);
  localparam logic [CW:0] LAST_CODE  = (CW+1)'((1 << CW) - 1);

  lzw_state_e    state_q, state_d;
  logic [CW-1:0] prefix_q, prefix_d;
  logic [7:0]    c_q, c_d;
  logic          last_q, last_d;
  logic [3:0]    probe_cnt_q, probe_cnt_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [CW:0]   next_code_q, next_code_d;
  logic          clear_pend_q, clear_pend_d;
  logic          clear_q, clear_d;
  logic          init_q;

  logic          tbl_rd_en;
  logic [CW-1:0] tbl_rd_addr;
  logic          tbl_rd_vld;
  logic [CW+7:0] tbl_rd_key;
  logic [CW-1:0] tbl_rd_code;
  logic          tbl_wr_en;
  logic [CW-1:0] slot_hash;
  logic          accept;
  logic          hit;
  logic          table_full;

  lzw_hash_table #(.CODE_WIDTH(CW)) u_table (
    .clk         (clk),
    .rst         (rst),
    .clear_all_i (clear_q),
    .rd_en_i     (tbl_rd_en),
    .rd_addr_i   (tbl_rd_addr),
    .rd_vld_o    (tbl_rd_vld),
    .rd_key_o    (tbl_rd_key),
    .rd_code_o   (tbl_rd_code),
    .wr_en_i     (tbl_wr_en),
    .wr_addr_i   (slot_q),
    .wr_key_i    ({prefix_q, c_q}),
    .wr_code_i   (next_code_q[CW-1:0])
  );

  assign slot_hash  = CW'(lzw_hash(CW, 16'(prefix_q), in_data));
  assign in_ready   = init_q && (state_q == IDLE || state_q == WAIT);
  assign accept     = in_valid && in_ready;
  assign hit        = tbl_rd_vld && (tbl_rd_key == {prefix_q, c_q});
  assign table_full = next_code_q[CW];

  always_comb begin
    state_d      = state_q;
    prefix_d     = prefix_q;
    c_d          = c_q;
    last_d       = last_q;
    probe_cnt_d  = probe_cnt_q;
    slot_d       = slot_q;
    next_code_d  = next_code_q;
    clear_pend_d = clear_pend_q;
    clear_d      = 1'b0;
    tbl_rd_en    = 1'b0;
    tbl_rd_addr  = slot_q;
    tbl_wr_en    = 1'b0;
    if (clear_q) begin
      next_code_d = FIRST_CODE;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          prefix_d = CW'(in_data);
          state_d  = in_last ? EMIT_LAST : WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          c_d         = in_data;
          last_d      = in_last;
          probe_cnt_d = '0;
          slot_d      = slot_hash;
          tbl_rd_en   = 1'b1;
          tbl_rd_addr = slot_hash;
          state_d     = PROBE;
        end
      end
      PROBE: begin
        if (hit) begin
          prefix_d = tbl_rd_code;
          state_d  = last_q ? EMIT_LAST : WAIT;
        end else if (!tbl_rd_vld) begin
          if (!table_full) begin
            tbl_wr_en   = 1'b1;
            next_code_d = next_code_q + (CW+1)'(1);
            if (FULL_MODE != 0 && next_code_q == LAST_CODE) begin
              clear_pend_d = 1'b1;
            end
          end
          state_d = EMIT;
        end else if (int'(probe_cnt_q) < PROBE_LIMIT - 1) begin
          probe_cnt_d = probe_cnt_q + 4'd1;
          slot_d      = slot_q + CW'(1);
          tbl_rd_en   = 1'b1;
          tbl_rd_addr = slot_q + CW'(1);
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          prefix_d = CW'(c_q);
          state_d  = last_q ? EMIT_LAST : WAIT;
          if (clear_pend_q) begin
            clear_d      = 1'b1;
            clear_pend_d = 1'b0;
          end
        end
      end
      EMIT_LAST: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prefix_q     <= '0;
      c_q          <= '0;
      last_q       <= 1'b0;
      probe_cnt_q  <= '0;
      slot_q       <= '0;
      next_code_q  <= FIRST_CODE;
      clear_pend_q <= 1'b0;
      clear_q      <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prefix_q     <= prefix_d;
      c_q          <= c_d;
      last_q       <= last_d;
      probe_cnt_q  <= probe_cnt_d;
      slot_q       <= slot_d;
      next_code_q  <= next_code_d;
      clear_pend_q <= clear_pend_d;
      clear_q      <= clear_d;
      init_q       <= 1'b1;
    end
  end

  // prefix only changes on a handshake, so the code is stable while stalled.
  assign out_valid = (state_q == EMIT) || (state_q == EMIT_LAST);
  assign out_last  = (state_q == EMIT_LAST);
  assign out_code  = prefix_q;
  assign dict_full = (FULL_MODE == 0) && next_code_q[CW];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lzw_stream_encoder.sv
// Scoreboard bench: a freeze-mode and a clear-mode encoder (CODE_WIDTH=9) driven by directed messages.
module tb_lzw_stream_encoder;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [7:0]    in_data   [2];
  logic          in_last   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [CW-1:0] out_code  [2];
  logic          out_last  [2];
  logic          dict_full [2];
  logic          busy      [2];

  logic [CW:0] expq0 [$];
  logic [CW:0] expq1 [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lzw_stream_encoder #(.CODE_WIDTH(CW), .PROBE_LIMIT(8), .FULL_MODE(0)) dut_frz (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_code(out_code[0]), .out_last(out_last[0]),
    .dict_full(dict_full[0]), .busy(busy[0])
  );

  lzw_stream_encoder #(.CODE_WIDTH(CW), .PROBE_LIMIT(8), .FULL_MODE(1)) dut_clr (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_code(out_code[1]), .out_last(out_last[1]),
    .dict_full(dict_full[1]), .busy(busy[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic expect_code(input int idx, input int code, input logic l);
    logic [CW:0] e;
    e = {l, CW'(code)};
    if (idx == 0) expq0.push_back(e);
    else expq1.push_back(e);
  endtask

  // Monitor: pop one expectation per output handshake.
  task automatic mon_step(input int idx);
    logic [CW:0] e;
    int n;
    if (out_valid[idx] && out_ready[idx]) begin
      n = (idx == 0) ? expq0.size() : expq1.size();
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected[%0d] actual=%0d expected=none", idx, out_code[idx]);
      end else begin
        if (idx == 0) e = expq0.pop_front();
        else e = expq1.pop_front();
        check($sformatf("out_code[%0d]", idx), int'(out_code[idx]), int'(e[CW-1:0]));
        check($sformatf("out_last[%0d]", idx), int'(out_last[idx]), int'(e[CW]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic send_byte(input int idx, input logic [7:0] d, input logic l);
    bit done;
    done = 1'b0;
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    in_last[idx]  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready[idx]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid[idx] = 1'b0;
    in_last[idx]  = 1'b0;
    if (!done) fail_timeout($sformatf("in_accept[%0d]", idx));
  endtask

  task automatic wait_drain(input int idx);
    int n;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      n = (idx == 0) ? expq0.size() : expq1.size();
      if (n == 0) break;
      @(negedge clk);
    end
    if (n != 0) fail_timeout($sformatf("drain[%0d]", idx));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int idx, input string tag);
    check($sformatf("%s_in_ready[%0d]", tag, idx), int'(in_ready[idx]), 0);
    check($sformatf("%s_out_valid[%0d]", tag, idx), int'(out_valid[idx]), 0);
    check($sformatf("%s_out_last[%0d]", tag, idx), int'(out_last[idx]), 0);
    check($sformatf("%s_out_code[%0d]", tag, idx), int'(out_code[idx]), 0);
    check($sformatf("%s_dict_full[%0d]", tag, idx), int'(dict_full[idx]), 0);
    check($sformatf("%s_busy[%0d]", tag, idx), int'(busy[idx]), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset(0, "rst");
    check_reset(1, "rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready[0]", int'(in_ready[0]), 1);
    check("rel_in_ready[1]", int'(in_ready[1]), 1);
  endtask

  task automatic send_abababa(input int idx);
    logic [7:0] s [7];
    s = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41};
    for (int i = 0; i < 7; i++) send_byte(idx, s[i], i == 6);
  endtask

  task automatic expect_abababa(input int idx);
    expect_code(idx, 65, 1'b0);
    expect_code(idx, 66, 1'b0);
    expect_code(idx, 256, 1'b0);
    expect_code(idx, 258, 1'b1);
  endtask

  task automatic pair_lit(input int idx, input int a, input int b);
    expect_code(idx, a, 1'b0);
    expect_code(idx, b, 1'b1);
    send_byte(idx, 8'(a), 1'b0);
    send_byte(idx, 8'(b), 1'b1);
    wait_drain(idx);
  endtask

  task automatic pair_hit(input int idx, input int a, input int b, input int code);
    expect_code(idx, code, 1'b1);
    send_byte(idx, 8'(a), 1'b0);
    send_byte(idx, 8'(b), 1'b1);
    wait_drain(idx);
  endtask

  // 256 pairs (a,1) fill codes 256..511 in collision-free slots a^2; then 44 pairs (a,0x80).
  task automatic fill_dictionary(input int idx);
    for (int a = 0; a < 256; a++) begin
      pair_lit(idx, a, 1);
      if (a == 254) check($sformatf("dict_full_before[%0d]", idx), int'(dict_full[idx]), 0);
    end
    check($sformatf("dict_full_after[%0d]", idx), int'(dict_full[idx]), (idx == 0) ? 1 : 0);
    for (int a = 0; a < 44; a++) pair_lit(idx, a, 8'h80);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      in_last[i]   = 1'b0;
      out_ready[i] = 1'b1;
    end
    #1;
    check_reset(0, "por");
    check_reset(1, "por");
    do_reset();

    // Basic compression with free-flowing output.
    expect_abababa(0);
    send_abababa(0);
    wait_drain(0);
    check("abab_busy", int'(busy[0]), 0);

    // Single-byte message.
    expect_code(0, 65, 1'b1);
    send_byte(0, 8'h41, 1'b1);
    wait_drain(0);
    check("single_busy", int'(busy[0]), 0);
    check("single_in_ready", int'(in_ready[0]), 1);

    // Output backpressure on the first EMIT.
    do_reset();
    out_ready[0] = 1'b0;
    expect_abababa(0);
    fork
      send_abababa(0);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          if (out_valid[0]) seen = 1'b1;
        end
        if (!seen) fail_timeout("stall_valid");
        repeat (5) begin
          @(negedge clk);
          check("stall_out_valid", int'(out_valid[0]), 1);
          check("stall_out_code", int'(out_code[0]), 65);
          check("stall_out_last", int'(out_last[0]), 0);
          check("stall_in_ready", int'(in_ready[0]), 0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    wait_drain(0);

    // Reset while a lookup is in PROBE.
    do_reset();
    send_byte(0, 8'h41, 1'b0);
    send_byte(0, 8'h42, 1'b0);
    check("probe_busy", int'(busy[0]), 1);
    rst = 1'b0;
    #1;
    check_reset(0, "mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", int'(in_ready[0]), 1);
    expect_code(0, 65, 1'b0);
    expect_code(0, 66, 1'b1);
    send_byte(0, 8'h41, 1'b0);
    send_byte(0, 8'h42, 1'b1);
    wait_drain(0);

    // Freeze mode: dictionary stops growing at 511 but keeps old entries.
    do_reset();
    fill_dictionary(0);
    pair_lit(0, 0, 8'h80);
    pair_hit(0, 0, 1, 256);
    pair_hit(0, 255, 1, 511);
    check("frz_dict_full_end", int'(dict_full[0]), 1);

    // Clear mode: dictionary restarts at 256 after 511 is used.
    do_reset();
    fill_dictionary(1);
    pair_hit(1, 0, 8'h80, 256);
    pair_hit(1, 43, 8'h80, 299);
    pair_lit(1, 0, 1);
    check("clr_dict_full_end", int'(dict_full[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzw_stream_encoder.md
LZW_STREAM_ENCODER -- requirements
Module: lzw_stream_encoder

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 12: output code width; dictionary codes span 0..2^CODE_WIDTH-1; legal range 9..16.
REQ-002 SHALL have parameter PROBE_LIMIT, default 8: maximum hash-table slots probed per lookup; legal range 1..16.
REQ-003 SHALL have parameter FULL_MODE, default 0: 0 = freeze dictionary when full; 1 = clear dictionary when full.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 8) and in_last (input, 1): byte stream; in_last marks the final byte.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_code (output, CODE_WIDTH) and out_last (output, 1): code stream.
REQ-008 SHALL have ports dict_full (output, 1), set when next_code > 2^CODE_WIDTH-1 in freeze mode, and busy (output, 1), high in every state except IDLE.

Function
REQ-009 SHALL reserve codes 0..255 for literal bytes and assign new codes from next_code = 256 upward, in order of insertion.
REQ-010 SHALL keep an open-addressed hash table of 2^CODE_WIDTH slots; each slot holds a valid bit, a key {prefix, byte} and a code.
REQ-011 SHALL compute slot = prefix XOR (byte << (CODE_WIDTH-8)), truncated to CODE_WIDTH bits; each probe advances slot+1 modulo 2^CODE_WIDTH.
REQ-012 SHALL implement states IDLE, WAIT, PROBE, EMIT and EMIT_LAST.
REQ-013 IDLE: in_ready=1; an accepted byte sets prefix=byte; go to EMIT_LAST if in_last, else WAIT.
REQ-014 WAIT: in_ready=1; an accepted byte c issues a table read at hash(prefix,c), latches c and in_last, clears probe_cnt, and goes to PROBE.
REQ-015 PROBE: table data returns 1 cycle after the read; one slot is compared per cycle; in_ready=0.
REQ-016 PROBE on a hit (valid and key match): prefix=slot code; go to EMIT_LAST if the latched last is set, else WAIT; no output.
REQ-017 PROBE on an empty slot: if not full, write {prefix,c,next_code} and increment next_code; set out_code=prefix; go to EMIT.
REQ-018 PROBE on a mismatch: if probe_cnt < PROBE_LIMIT-1, increment probe_cnt and read the next slot; otherwise emit prefix with no insert and go to EMIT.
REQ-019 EMIT: out_valid=1 with out_code held stable until out_ready; on handshake prefix=c, then go to EMIT_LAST if the latched last is set, else WAIT.
REQ-020 EMIT_LAST: out_valid=1, out_last=1, out_code=prefix; on handshake go to IDLE.
REQ-021 When a write makes next_code = 2^CODE_WIDTH in freeze mode, SHALL set dict_full=1 and suppress all later inserts while still emitting normally.
REQ-022 In clear mode, the same event SHALL clear all valid bits in the cycle after the EMIT handshake, reset next_code=256, and keep dict_full=0.
REQ-023 out_valid SHALL never drop before its handshake, and out_code and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 The output handshake is independent: an out_ready asserted while out_valid=0 SHALL be ignored.

Reset
REQ-025 On rst low, SHALL immediately force state=IDLE, all valid bits=0, next_code=256, prefix=0, probe_cnt=0, in_ready=0, out_valid=0, out_last=0, out_code=0, dict_full=0 and busy=0.
REQ-026 SHALL assert in_ready=1 on the first clock after rst deasserts; a reset during PROBE or EMIT SHALL discard the transaction with no partial write.

Structure
REQ-027 Package lzw_pkg SHALL hold: the state enum, LITERAL_CODES=256, and the hash function taking a CODE_WIDTH parameter.
REQ-028 Sub-module lzw_hash_table SHALL hold the synchronous 1-cycle-read key/code RAM, the flop valid-bit array and a single-cycle clear_all input.

Verification
REQ-029 Feed "ABABABA" (0x41,0x42,...) with last on the final byte and out_ready=1 -> codes 65, 66, 256, 258, with out_last only on 258.
REQ-030 Feed single byte 0x41 with in_last -> exactly one code 65 with out_last=1, then IDLE with busy=0.
REQ-031 Hold out_ready=0 for 5 cycles during EMIT -> out_code stable, in_ready=0 and no lost bytes; the output stream matches REQ-029.
REQ-032 CODE_WIDTH=9, FULL_MODE=0, 300 distinct byte pairs -> dict_full rises after code 511 is assigned; later pairs emit literals only.
REQ-033 CODE_WIDTH=9, FULL_MODE=1, same stimulus -> after code 511 the next insert is assigned 256, and a repeated early pair is re-emitted as literals.
REQ-034 Drop rst low during PROBE -> outputs are at reset values immediately; a following "AB" with last emits 65, then 66 with out_last.
